// File: rtl/matrix_packer.sv
// Purpose : collects a rows x cols matrix streamed element by element (row-major)
//           and presents it as one flat packed bus until the consumer acks it.
// Ports   : clk/reset (sync, active-high); start/rows/cols open a load;
//           in_data/in_valid/in_ready element stream; out_mat/out_rows/out_cols/
//           out_valid/out_ack result handshake; busy/error status.
// Latency : out_valid rises the cycle after the last element handshake; in_ready
//           rises the cycle after an accepted start.
// Backpressure: in_ready is high throughout LOAD; a gap in in_valid simply stalls.
//           The result is held until out_ack.
// Config  : define MATRIX_PACKER_DIM_CHECK_EN to reject rows/cols of 0 or > MAX_DIM
//           (ERROR state). Without it, ERROR is unreachable. A 0-element start goes
//           straight to HOLD, and elements beyond the bus are accepted and dropped.
module matrix_packer #(
    parameter int ELEM_W  = 32,
    parameter int MAX_DIM = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [7:0]                          rows,
    input  logic [7:0]                          cols,
    input  logic [ELEM_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   out_mat,
    output logic [7:0]                          out_rows,
    output logic [7:0]                          out_cols,
    output logic                                out_valid,
    input  logic                                out_ack,
    output logic                                busy,
    output logic                                error
);

    localparam int MAT_W = MAX_DIM*MAX_DIM*ELEM_W;
    localparam int NELEM = MAX_DIM*MAX_DIM;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_HOLD  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         rows_q, rows_d;
    logic [7:0]         cols_q, cols_d;
    logic [15:0]        k_q, k_d;
    logic [MAT_W-1:0]   mat_q, mat_d;

    logic               start_acc;
    logic               hs;
    logic               last_hs;
    logic [15:0]        total;

    // Element counts kept at full 16-bit width (255*255 fits without wrap).
    assign total     = 16'(rows_q) * 16'(cols_q);
    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_ERROR));
    assign hs        = in_valid && (state_q == S_LOAD);
    assign last_hs   = hs && (k_q == total - 16'd1);

`ifdef MATRIX_PACKER_DIM_CHECK_EN
    localparam logic [8:0] MAX_DIM_U = 9'(MAX_DIM);
    logic dim_ok;
    assign dim_ok = (rows != 8'd0) && (cols != 8'd0) &&
                    ({1'b0, rows} <= MAX_DIM_U) && ({1'b0, cols} <= MAX_DIM_U);
`else
    logic [15:0] start_total;
    assign start_total = 16'(rows) * 16'(cols);
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            k_q     <= '0;
            mat_q   <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            k_q     <= k_d;
            mat_q   <= mat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
`ifdef MATRIX_PACKER_DIM_CHECK_EN
                    state_d = dim_ok ? S_LOAD : S_ERROR;
`else
                    // An empty matrix has nothing to load: present it at once.
                    state_d = (start_total == 16'd0) ? S_HOLD : S_LOAD;
`endif
                end
            end
            S_LOAD:  if (last_hs) state_d = S_HOLD;
            S_HOLD:  if (out_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch dims / clear on start, pack on handshake
    always_comb begin
        rows_d = rows_q;
        cols_d = cols_q;
        k_d    = k_q;
        mat_d  = mat_q;
        if (start_acc) begin
            rows_d = rows;
            cols_d = cols;
            k_d    = '0;
            mat_d  = '0;
        end else if (hs) begin
            k_d = k_q + 16'd1;
            // Slots past the end of the bus have no home; those elements are dropped.
            for (int e = 0; e < NELEM; e++) begin
                if (k_q == 16'(e)) mat_d[e*ELEM_W +: ELEM_W] = in_data;
            end
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        busy      = (state_q == S_LOAD) || (state_q == S_HOLD);
        out_valid = (state_q == S_HOLD);
`ifdef MATRIX_PACKER_DIM_CHECK_EN
        error     = (state_q == S_ERROR);
`else
        error     = 1'b0;
`endif
        out_mat   = mat_q;
        out_rows  = rows_q;
        out_cols  = cols_q;
    end

endmodule
